// File: rtl/pcie_link_led_pkg.sv
// Shared LTSSM codes, link FSM state encoding and negotiated-speed codes for the link LED block.
package pcie_link_led_pkg;

  localparam logic [4:0] LTSSM_DET_QUIET  = 5'h00;
  localparam logic [4:0] LTSSM_COMPLIANCE = 5'h03;
  localparam logic [4:0] LTSSM_RCV_LOCK   = 5'h0C;
  localparam logic [4:0] LTSSM_RCV_CFG    = 5'h0D;
  localparam logic [4:0] LTSSM_RCV_IDLE   = 5'h0E;
  localparam logic [4:0] LTSSM_L0         = 5'h0F;

  localparam logic [1:0] SPD_UNKNOWN = 2'd0;
  localparam logic [1:0] SPD_GEN1    = 2'd1;
  localparam logic [1:0] SPD_GEN2    = 2'd2;
  localparam logic [1:0] SPD_GEN3    = 2'd3;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_L0_PEND = 2'd2,
    ST_UP      = 2'd3
  } link_st_t;

endpackage

// File: rtl/pcie_link_led_fsm.sv
// Debounced link FSM: link_up after L0_STABLE_CYC consecutive L0 cycles, plus a
// saturating count of drops out of UP (clear has priority over an increment).
module pcie_link_led_fsm
  import pcie_link_led_pkg::*;
#(
  parameter int L0_STABLE_CYC = 1024,
  parameter int LDN_CNT_W     = 8
) (
  input  logic                 pld_clk,
  input  logic                 srst,
  input  logic [4:0]           ltssm,
  input  logic                 cnt_clr,
  output logic                 link_up,
  output logic [LDN_CNT_W-1:0] ldn_cnt
);

  localparam int DBC_W = (L0_STABLE_CYC > 2) ? $clog2(L0_STABLE_CYC) : 1;
  // The TRAIN cycle that saw L0 counts as the first stable cycle.
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(L0_STABLE_CYC - 2);

  link_st_t         state;
  logic [DBC_W-1:0] dbc;
  logic             is_l0;
  logic             is_rcv;
  logic             ldn_evt;

  assign is_l0   = (ltssm == LTSSM_L0);
  assign is_rcv  = (ltssm == LTSSM_RCV_LOCK) || (ltssm == LTSSM_RCV_CFG) ||
                   (ltssm == LTSSM_RCV_IDLE);
  assign ldn_evt = (state == ST_UP) && !(is_l0 || is_rcv);

  always_ff @(posedge pld_clk) begin
    if (srst) begin
      state   <= ST_DOWN;
      dbc     <= '0;
      link_up <= 1'b0;
    end else begin
      case (state)
        ST_DOWN: begin
          if (ltssm != LTSSM_DET_QUIET) state <= ST_TRAIN;
          link_up <= 1'b0;
        end
        ST_TRAIN: begin
          if (is_l0) begin
            state <= ST_L0_PEND;
            dbc   <= '0;
          end else if (ltssm == LTSSM_DET_QUIET) begin
            state <= ST_DOWN;
          end
          link_up <= 1'b0;
        end
        ST_L0_PEND: begin
          if (!is_l0) begin
            state   <= ST_TRAIN;
            link_up <= 1'b0;
          end else if (dbc == DBC_LAST) begin
            state   <= ST_UP;
            dbc     <= dbc + 1'b1;
            link_up <= 1'b1;
          end else begin
            dbc     <= dbc + 1'b1;
            link_up <= 1'b0;
          end
        end
        default: begin
          if (ldn_evt) begin
            state   <= (ltssm == LTSSM_DET_QUIET) ? ST_DOWN : ST_TRAIN;
            link_up <= 1'b0;
          end else begin
            link_up <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge pld_clk) begin
    if (srst || cnt_clr) begin
      ldn_cnt <= '0;
    end else if (ldn_evt && (ldn_cnt != '1)) begin
      ldn_cnt <= ldn_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcie_link_status_led.sv
// PCIe link-status LEDs (active-low): heartbeat, compliance, L0, speed and lane bar.
// Define PCIE_LINK_LED_LTSSM_SYNC_EN to double-register the core status inputs (+2 cycles).
module pcie_link_status_led
  import pcie_link_led_pkg::*;
#(
  parameter int LANE_W        = 8,
  parameter int ALIVE_DIV_W   = 26,
  parameter int L0_STABLE_CYC = 1024,
  parameter int LDN_CNT_W     = 8
) (
  input  logic                         pld_clk,
  input  logic                         srst,
  input  logic [4:0]                   ltssm_state,
  input  logic [1:0]                   link_speed,
  input  logic [$clog2(LANE_W+1)-1:0]  lane_num,
  input  logic                         cnt_clr,
  output logic                         alive_led,
  output logic                         comp_led,
  output logic                         l0_led,
  output logic                         speed_led,
  output logic [LANE_W-1:0]            lane_led,
  output logic                         link_up,
  output logic [LDN_CNT_W-1:0]         ldn_cnt
);

  localparam int LN_W = $clog2(LANE_W + 1);

  logic [4:0]             ltssm_use;
  logic [1:0]             speed_use;
  logic [LN_W-1:0]        lane_use;
  logic [ALIVE_DIV_W-1:0] hb_cnt;
  logic [LANE_W-1:0]      lane_nxt;
  logic                   speed_nxt;

`ifdef PCIE_LINK_LED_LTSSM_SYNC_EN
  logic [4:0]      ltssm_s1, ltssm_s2;
  logic [1:0]      speed_s1, speed_s2;
  logic [LN_W-1:0] lane_s1, lane_s2;

  always_ff @(posedge pld_clk) begin
    if (srst) begin
      ltssm_s1 <= '0;
      ltssm_s2 <= '0;
      speed_s1 <= '0;
      speed_s2 <= '0;
      lane_s1  <= '0;
      lane_s2  <= '0;
    end else begin
      ltssm_s1 <= ltssm_state;
      ltssm_s2 <= ltssm_s1;
      speed_s1 <= link_speed;
      speed_s2 <= speed_s1;
      lane_s1  <= lane_num;
      lane_s2  <= lane_s1;
    end
  end

  assign ltssm_use = ltssm_s2;
  assign speed_use = speed_s2;
  assign lane_use  = lane_s2;
`else
  assign ltssm_use = ltssm_state;
  assign speed_use = link_speed;
  assign lane_use  = lane_num;
`endif

  pcie_link_led_fsm #(
    .L0_STABLE_CYC (L0_STABLE_CYC),
    .LDN_CNT_W     (LDN_CNT_W)
  ) u_fsm (
    .pld_clk (pld_clk),
    .srst    (srst),
    .ltssm   (ltssm_use),
    .cnt_clr (cnt_clr),
    .link_up (link_up),
    .ldn_cnt (ldn_cnt)
  );

  assign l0_led = ~link_up;

  // Lanes beyond the negotiated width stay dark; over-range widths light the whole bar.
  always_comb begin
    lane_nxt = '1;
    if (link_up) begin
      for (int i = 0; i < LANE_W; i++) begin
        if (i < int'(lane_use)) lane_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    speed_nxt = 1'b1;
    if (link_up) begin
      case (speed_use)
        SPD_GEN2: speed_nxt = 1'b0;
        SPD_GEN3: speed_nxt = hb_cnt[ALIVE_DIV_W-3];
        default:  speed_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge pld_clk) begin
    if (srst) begin
      hb_cnt    <= '0;
      alive_led <= 1'b1;
      comp_led  <= 1'b1;
      speed_led <= 1'b1;
      lane_led  <= '1;
    end else begin
      hb_cnt    <= hb_cnt + 1'b1;
      alive_led <= hb_cnt[ALIVE_DIV_W-1];
      comp_led  <= ~(ltssm_use == LTSSM_COMPLIANCE);
      speed_led <= speed_nxt;
      lane_led  <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_pcie_link_status_led.sv
// Directed bench for pcie_link_status_led with L0_STABLE_CYC=16, ALIVE_DIV_W=6, LANE_W=8.
module tb_pcie_link_status_led;

`ifdef PCIE_LINK_LED_LTSSM_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       pld_clk = 1'b0;
  logic       srst;
  logic [4:0] ltssm_state;
  logic [1:0] link_speed;
  logic [3:0] lane_num;
  logic       cnt_clr;
  logic       alive_led, comp_led, l0_led, speed_led, link_up;
  logic [7:0] lane_led;
  logic [7:0] ldn_cnt;

  int total = 0;
  int bad   = 0;

  always #5 pld_clk = ~pld_clk;

  pcie_link_status_led #(
    .LANE_W        (8),
    .ALIVE_DIV_W   (6),
    .L0_STABLE_CYC (16),
    .LDN_CNT_W     (8)
  ) u_dut (
    .pld_clk     (pld_clk),
    .srst        (srst),
    .ltssm_state (ltssm_state),
    .link_speed  (link_speed),
    .lane_num    (lane_num),
    .cnt_clr     (cnt_clr),
    .alive_led   (alive_led),
    .comp_led    (comp_led),
    .l0_led      (l0_led),
    .speed_led   (speed_led),
    .lane_led    (lane_led),
    .link_up     (link_up),
    .ldn_cnt     (ldn_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pld_clk);
  endtask

  initial begin
    int ntog, nalive, bad_gap, last, lat;
    logic prev_spd, prev_alive;

    srst = 1'b1; ltssm_state = 5'h0F; link_speed = 2'd0; lane_num = 4'd0; cnt_clr = 1'b0;
    step(3);
    chk("rst_alive", alive_led, 1'b1);
    chk("rst_comp",  comp_led,  1'b1);
    chk("rst_l0",    l0_led,    1'b1);
    chk("rst_speed", speed_led, 1'b1);
    chk("rst_lane",  lane_led,  8'hFF);
    chk("rst_lu",    link_up,   1'b0);
    chk("rst_ldn",   ldn_cnt,   8'd0);

    // link_up on the 17th edge after release with L0 held
    srst = 1'b0;
    step(16 + SL);
    chk("lu_edge16", link_up, 1'b0);
    step(1);
    chk("lu_edge17", link_up, 1'b1);
    chk("l0_led_up", l0_led,  1'b0);

    // Recovery keeps the link up; DET_QUIET drops it on the next edge
    ltssm_state = 5'h0C; step(SL + 2);
    chk("lu_rcv", link_up, 1'b1);
    ltssm_state = 5'h0F; step(SL + 2);
    chk("lu_back_l0", link_up, 1'b1);
    ltssm_state = 5'h00; step(SL);
    chk("lu_pre_drop", link_up, 1'b1);
    step(1);
    chk("lu_drop", link_up, 1'b0);
    chk("ldn_one", ldn_cnt, 8'd1);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    chk("ldn_clr", ldn_cnt, 8'd0);

    // Abort debounce at count 10; full 16 L0 cycles needed again
    ltssm_state = 5'h0F; step(SL + 12);
    ltssm_state = 5'h02; step(1);
    ltssm_state = 5'h0F; step(SL + 15);
    chk("pend_abort_lu",  link_up, 1'b0);
    chk("pend_abort_ldn", ldn_cnt, 8'd0);
    step(1);
    chk("pend_reup", link_up, 1'b1);

    lane_num = 4'd4; step(SL + 1);
    chk("lane4", lane_led, 8'hF0);
    lane_num = 4'd9; step(SL + 1);
    chk("lane9", lane_led, 8'h00);
    lane_num = 4'd0; step(SL + 1);
    chk("lane0", lane_led, 8'hFF);
    lane_num = 4'd8; step(SL + 1);
    chk("lane8", lane_led, 8'h00);

    link_speed = 2'd2; step(SL + 1);
    chk("spd_gen2", speed_led, 1'b0);
    link_speed = 2'd1; step(SL + 1);
    chk("spd_gen1", speed_led, 1'b1);
    link_speed = 2'd3; step(SL + 2);
    // Gen3 blink follows counter bit 3: a change every 8 cycles; heartbeat every 32
    ntog = 0; nalive = 0; bad_gap = 0; last = -1;
    prev_spd = speed_led; prev_alive = alive_led;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (speed_led != prev_spd) begin
        ntog++;
        if (last >= 0 && (i - last) != 8) bad_gap++;
        last = i;
      end
      if (alive_led != prev_alive) nalive++;
      prev_spd = speed_led; prev_alive = alive_led;
    end
    chk("spd_gen3_toggles", ntog,    8);
    chk("spd_gen3_gaps",    bad_gap, 0);
    chk("alive_toggles",    nalive,  2);

    ltssm_state = 5'h00; lane_num = 4'd4; step(SL + 2);
    chk("down_lane",  lane_led,  8'hFF);
    chk("down_speed", speed_led, 1'b1);
    chk("down_l0",    l0_led,    1'b1);
    chk("down_ldn",   ldn_cnt,   8'd1);

    // 300 link-down events: saturate at 255
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    ltssm_state = 5'h0F; step(17);
    for (int k = 1; k <= 300; k++) begin
      ltssm_state = 5'h01; step(1);
      ltssm_state = 5'h0F; step(SL + 1);
      if (k == 100) chk("ldn_100", ldn_cnt, 8'd100);
      step(15 - SL);
    end
    chk("ldn_sat", ldn_cnt, 8'd255);
    ltssm_state = 5'h01; step(SL);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    chk("ldn_clr_wins", ldn_cnt, 8'd0);
    chk("lu_after_evt", link_up, 1'b0);

    ltssm_state = 5'h03;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (comp_led == 1'b0 && lat == 0) lat = i;
    end
    chk("comp_latency", lat, 1 + SL);
    ltssm_state = 5'h00; step(SL + 1);
    chk("comp_off", comp_led, 1'b1);

    // Mid-operation reset clears everything on the same edge
    ltssm_state = 5'h0F; step(SL + 18);
    chk("pre_rst_lu", link_up, 1'b1);
    step(SL + 1);
    chk("pre_rst_lane", lane_led, 8'hF0);
    srst = 1'b1; step(1);
    chk("mid_rst_lu",    link_up,  1'b0);
    chk("mid_rst_lane",  lane_led, 8'hFF);
    chk("mid_rst_l0",    l0_led,   1'b1);
    chk("mid_rst_alive", alive_led, 1'b1);
    srst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
